// File: rtl/act_pkg.sv
// ============================================================================
// act_pkg : FSM state encoding and frame-length helper for act_cfg_loader.
// Optional feature macro: ACT_CFG_PARITY_EN (adds one even-parity bit).
// Rev 1.0
// ============================================================================
`default_nettype none

package act_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  // Serial frame length: four data words of b bits, plus parity when enabled.
  function automatic int frame_len(input int b);
`ifdef ACT_CFG_PARITY_EN
    return 4 * b + 1;
`else
    return 4 * b;
`endif
  endfunction

endpackage

`default_nettype wire

// File: rtl/act_cfg_loader_if.sv
// ============================================================================
// act_cfg_loader_if : serial configuration handshake (start, valid/ready, bit).
// Rev 1.0
// ============================================================================
`default_nettype none

interface act_cfg_loader_if;
  logic start;
  logic cfg_valid;
  logic cfg_bit;
  logic cfg_ready;

  modport master (
    output start,
    output cfg_valid,
    output cfg_bit,
    input  cfg_ready
  );

  modport slave (
    input  start,
    input  cfg_valid,
    input  cfg_bit,
    output cfg_ready
  );
endinterface

`default_nettype wire

// File: rtl/act_cfg_shreg.sv
// ============================================================================
// act_cfg_shreg : shadow shift register; first bit shifted in ends at bit 0.
// Rev 1.0
// ============================================================================
`default_nettype none

module act_cfg_shreg #(
  parameter int W = 8
) (
  input  wire logic         clock,
  input  wire logic         reset,
  input  wire logic         i_clr,
  input  wire logic         i_shift_en,
  input  wire logic         i_bit,
  output logic [W-1:0]      o_data
);

  logic [W-1:0] r_data;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_data <= '0;
    end else if (i_clr) begin
      r_data <= '0;
    end else if (i_shift_en) begin
      r_data <= {i_bit, r_data[W-1:1]};
    end
  end

  assign o_data = r_data;

endmodule

`default_nettype wire

// File: rtl/act_cfg_loader.sv
// ============================================================================
// act_cfg_loader : serial loader committing four data words to an _ACT_S2 cell.
// Optional feature macro: ACT_CFG_PARITY_EN (trailing even-parity bit, err).
// Rev 1.0
// ============================================================================
`default_nettype none

module act_cfg_loader
  import act_pkg::*;
#(
  parameter int bits = 2
) (
  input  wire logic          clock,
  input  wire logic          reset,
  act_cfg_loader_if.slave    cfg,
  output logic [bits-1:0]    D00,
  output logic [bits-1:0]    D01,
  output logic [bits-1:0]    D10,
  output logic [bits-1:0]    D11,
  output logic               loaded,
  output logic               done,
  output logic               err
);

  localparam int N  = frame_len(bits);
  localparam int CW = $clog2(N + 1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_nxt;
  logic            w_shift;
  logic            w_clr;
  logic            w_xfer;
  logic            w_par_ok;
  logic [N-1:0]    w_shadow;

  logic [bits-1:0] r_d00;
  logic [bits-1:0] r_d01;
  logic [bits-1:0] r_d10;
  logic [bits-1:0] r_d11;
  logic            r_loaded;
  logic            r_done;

  // Ready is gated by reset so it drops combinationally, not on the next edge.
  assign cfg.cfg_ready = reset & (r_state == SHIFT);
  assign w_xfer        = cfg.cfg_valid & cfg.cfg_ready;

  act_cfg_shreg #(
    .W (N)
  ) u_shreg (
    .clock      (clock),
    .reset      (reset),
    .i_clr      (w_clr),
    .i_shift_en (w_shift),
    .i_bit      (cfg.cfg_bit),
    .o_data     (w_shadow)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_shift     = 1'b0;
    w_clr       = 1'b0;
    case (r_state)
      IDLE: begin
        if (cfg.start) begin
          w_state_nxt = SHIFT;
          w_cnt_nxt   = '0;
          w_clr       = 1'b1;
        end
      end
      SHIFT: begin
        // A restart wins over any transfer presented in the same cycle.
        if (cfg.start) begin
          w_cnt_nxt = '0;
          w_clr     = 1'b1;
        end else if (w_xfer) begin
          w_shift   = 1'b1;
          w_cnt_nxt = r_cnt + CW'(1);
          if (r_cnt == CW'(N - 1)) begin
            w_state_nxt = COMMIT;
          end
        end
      end
      COMMIT: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

`ifdef ACT_CFG_PARITY_EN
  logic r_err;

  // Even parity: payload plus parity bit must XOR to zero.
  assign w_par_ok = ~(^w_shadow);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_err <= 1'b0;
    end else begin
      r_err <= (r_state == COMMIT) & ~w_par_ok;
    end
  end

  assign err = r_err;
`else
  assign w_par_ok = 1'b1;
  assign err      = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_d00    <= '0;
      r_d01    <= '0;
      r_d10    <= '0;
      r_d11    <= '0;
      r_loaded <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if ((r_state == COMMIT) && w_par_ok) begin
        r_d00    <= w_shadow[bits-1:0];
        r_d01    <= w_shadow[2*bits-1:bits];
        r_d10    <= w_shadow[3*bits-1:2*bits];
        r_d11    <= w_shadow[4*bits-1:3*bits];
        r_loaded <= 1'b1;
        r_done   <= 1'b1;
      end
    end
  end

  assign D00    = r_d00;
  assign D01    = r_d01;
  assign D10    = r_d10;
  assign D11    = r_d11;
  assign loaded = r_loaded;
  assign done   = r_done;

endmodule

`default_nettype wire

// File: doc/act_cfg_loader.md
ACT_CFG_LOADER -- requirements
Module: act_cfg_loader

Interface
REQ-001 The block SHALL have parameter `bits`, default 2, giving the width of each data word driven to the downstream _ACT_S2-style cell.
REQ-002 The block SHALL have port `clock`, input, width 1: the single rising-edge clock.
REQ-003 The block SHALL have port `reset`, input, width 1: asynchronous, active-low reset.
REQ-004 The block SHALL have port `start`, input, width 1: begin or restart a configuration frame.
REQ-005 The block SHALL have port `cfg_valid`, input, width 1: `cfg_bit` is valid.
REQ-006 The block SHALL have port `cfg_bit`, input, width 1: serial configuration data.
REQ-007 The block SHALL have port `cfg_ready`, output, width 1: loader accepts a bit this cycle.
REQ-008 The block SHALL have ports `D00`, `D01`, `D10`, `D11`, outputs, width `bits` each: committed data words for the downstream cell.
REQ-009 The block SHALL have port `loaded`, output, width 1: at least one frame has been committed since reset.
REQ-010 The block SHALL have port `done`, output, width 1: one-cycle pulse on commit.
REQ-011 The block SHALL have port `err`, output, width 1: one-cycle pulse on parity failure (see Configuration).

Function
REQ-012 Frame length N SHALL be 4*bits payload bits, plus 1 parity bit when ACT_CFG_PARITY_EN is defined.
REQ-013 A bit SHALL transfer on a rising edge where `cfg_valid` and `cfg_ready` are both 1; `cfg_bit` is ignored otherwise.
REQ-014 Bit order SHALL be: first accepted bit to D00[0], through D00[bits-1], then D01[0..bits-1], D10[0..bits-1], D11[0..bits-1].
REQ-015 Accepted bits SHALL go to an internal shadow register; D outputs SHALL change only on commit, never mid-frame.
REQ-016 The FSM SHALL have states IDLE, SHIFT and COMMIT.
REQ-017 In IDLE: `cfg_ready`=0; `start`=1 moves to SHIFT with the bit counter cleared to 0.
REQ-018 In SHIFT: `cfg_ready`=1; each transfer increments the counter; the transfer of bit N-1 moves to COMMIT.
REQ-019 In COMMIT (exactly one cycle): `cfg_ready`=0; on the next edge the shadow is copied to D00..D11, `done`=1 and `loaded`=1 are registered, and the FSM returns to IDLE.
REQ-020 Latency SHALL be: `done` and the new D values become visible together, one cycle after the edge accepting the final bit.
REQ-021 `start` in SHIFT SHALL restart the frame: counter cleared to 0, any simultaneous transfer discarded, D outputs unchanged.
REQ-022 `start` in COMMIT SHALL be ignored.
REQ-023 The bit counter width SHALL be clog2(N+1); the counter SHALL never wrap.
REQ-024 `done` and `err` SHALL never be 1 in the same cycle.

Reset
REQ-025 On `reset`=0, asynchronously: state=IDLE, counter=0, shadow=0, D00..D11=0, `loaded`=0, `done`=0, `err`=0.
REQ-026 On `reset`=0, `cfg_ready` SHALL be 0 combinationally.
REQ-027 Reset mid-frame SHALL discard the partial frame; previously committed values are lost.

Configuration
REQ-028 When macro ACT_CFG_PARITY_EN is defined, the bit after the payload SHALL be even parity over the payload.
REQ-029 With ACT_CFG_PARITY_EN defined, a parity mismatch in COMMIT SHALL skip the copy, pulse `err` for one cycle, and leave `done`, `loaded` and the D outputs unchanged.
REQ-030 Without ACT_CFG_PARITY_EN, N SHALL be 4*bits and `err` SHALL be tied to 0.

Structure
REQ-031 Package act_pkg SHALL hold the FSM state encoding (IDLE, SHIFT, COMMIT) and the frame-length function N(bits).
REQ-032 Sub-module act_cfg_shreg SHALL hold the shadow shift register with shift-enable and clear inputs; the FSM and output registers SHALL stay in act_cfg_loader.

Verification (bits=2, N=8, or 9 with parity)
REQ-033 Reset, start, stream 1,0, 0,1, 1,1, 0,0 -> D00=2'b01, D01=2'b10, D10=2'b11, D11=2'b00 and `done`=1 one cycle after the 8th bit; `loaded`=1.
REQ-034 Same frame with `cfg_valid` toggling every other cycle -> identical result; no D change before commit.
REQ-035 Start, 5 bits, start again, then a full frame of all 1s -> all D words 2'b11; the first 5 bits have no effect.
REQ-036 Assert `reset`=0 after 6 bits of a frame following one committed frame -> all D=0, `loaded`=0, state IDLE immediately (asynchronous).
REQ-037 With ACT_CFG_PARITY_EN, payload 0xFF with parity bit 1 -> `err` pulses for one cycle, D unchanged, `done` stays 0.
REQ-038 With ACT_CFG_PARITY_EN, payload 0xFF with parity bit 0 -> commit succeeds.
